// File: rtl/mux_2to1.sv
// 2:1 mux with a registered output copy and select-change tracking (pulse + saturating count).
// Optional toggle counter is enabled by defining MUX_2TO1_TOGGLE_CNT_EN; otherwise toggle_cnt is 0.
module mux_2to1 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_toggle,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic sel_q;
    logic sel_toggle_q;
    logic sel_change;

    // Ternary gives the bitwise d0/d1 merge in simulation when sel is X/Z.
    assign y          = sel ? d1 : d0;
    assign sel_change = (sel != sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q          <= '0;
            sel_q        <= 1'b0;
            sel_toggle_q <= 1'b0;
        end else begin
            y_q          <= y;
            sel_q        <= sel;
            sel_toggle_q <= sel_change;
        end
    end

    assign sel_toggle = sel_toggle_q;

`ifdef MUX_2TO1_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sel_change && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign toggle_cnt = cnt_q;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: idle-clock truth table, directed corner sequences,
// and randomized stimulus against a history-based reference model.
module tb_mux_2to1;

`ifdef MUX_2TO1_TOGGLE_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif
    localparam int unsigned CntW   = 2;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            clk_run = 1'b0;
    logic            rst = 1'b0;
    logic            d0 = 1'b0;
    logic            d1 = 1'b0;
    logic            sel = 1'b0;
    logic            y;
    logic            y_q;
    logic            sel_toggle;
    logic [CntW-1:0] toggle_cnt;

    int n_checks = 0;
    int n_err    = 0;

    mux_2to1 #(
        .WIDTH (1),
        .CNT_W (CntW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .d0         (d0),
        .d1         (d1),
        .sel        (sel),
        .y          (y),
        .y_q        (y_q),
        .sel_toggle (sel_toggle),
        .toggle_cnt (toggle_cnt)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic d0;
        logic d1;
        logic sel;
        logic exp_y;
    } vec_t;

    // Reference model: list of sel values seen at each edge since reset (index 0 = reset value).
    bit          hist[$];
    logic        e_yq;
    logic        e_tog;
    int unsigned e_cnt;
    bit          model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned count_changes();
        int unsigned c = 0;
        for (int i = 1; i < hist.size(); i++) begin
            if (hist[i] != hist[i-1]) c++;
        end
        return c;
    endfunction

    // One clock edge: update the model from the pre-edge inputs, then compare after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            hist        = {1'b0};
            e_yq        = 1'b0;
            e_tog       = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            e_yq = sel ? d1 : d0;
            hist.push_back(sel);
            e_tog = (hist[hist.size()-1] != hist[hist.size()-2]);
        end
        if (model_valid) begin
            e_cnt = CntEn ? ((count_changes() > CntMax) ? CntMax : count_changes()) : 0;
        end
        #1;
        if (model_valid) begin
            check("y_q", {31'd0, y_q}, {31'd0, e_yq});
            check("sel_toggle", {31'd0, sel_toggle}, {31'd0, e_tog});
            check("toggle_cnt", {30'd0, toggle_cnt}, e_cnt);
            check("y_live", {31'd0, y}, {31'd0, (sel ? d1 : d0)});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   pulses;
        int   cnt_exp[6];

        // Truth table with the clock idle.
        for (int i = 0; i < 8; i++) begin
            vecs[i].d0    = i[2];
            vecs[i].d1    = i[1];
            vecs[i].sel   = i[0];
            vecs[i].exp_y = i[0] ? i[1] : i[2];
        end
        for (int i = 0; i < 8; i++) begin
            d0  = vecs[i].d0;
            d1  = vecs[i].d1;
            sel = vecs[i].sel;
            #10;
            check($sformatf("table_y[%0d]", i), {31'd0, y}, {31'd0, vecs[i].exp_y});
        end

        clk_run = 1'b1;
        d0 = 1'b0; d1 = 1'b0; sel = 1'b0;
        do_reset();
        check("reset_yq", {31'd0, y_q}, 32'd0);
        check("reset_tog", {31'd0, sel_toggle}, 32'd0);
        check("reset_cnt", {30'd0, toggle_cnt}, 32'd0);

        // Registered copy lags y by one edge.
        d0 = 1'b1; d1 = 1'b0; sel = 1'b0;
        step();
        check("yq_after_edge", {31'd0, y_q}, 32'd1);
        sel = 1'b1;
        #1;
        check("y_immediate", {31'd0, y}, 32'd0);
        check("yq_not_yet", {31'd0, y_q}, 32'd1);
        step();
        check("yq_follow", {31'd0, y_q}, 32'd0);

        // Held select change gives exactly one pulse.
        sel = 1'b0;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(sel_toggle);
        end
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(sel_toggle);
        end
        check("single_pulse", pulses, 32'd1);
        check("single_cnt", {30'd0, toggle_cnt}, CntEn ? 32'd1 : 32'd0);

        // Alternating select: pulse every cycle, counter saturates at 3.
        sel = 1'b0;
        do_reset();
        cnt_exp = '{1, 2, 3, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            sel = ~sel;
            step();
            check($sformatf("alt_pulse[%0d]", i), {31'd0, sel_toggle}, 32'd1);
            check($sformatf("alt_cnt[%0d]", i), {30'd0, toggle_cnt},
                  CntEn ? cnt_exp[i] : 32'd0);
        end

        // Reset wins over a pending toggle while saturated; y stays live.
        rst = 1'b1;
        sel = ~sel;
        d0  = 1'b1; d1 = 1'b1;
        step();
        check("rst_yq", {31'd0, y_q}, 32'd0);
        check("rst_tog", {31'd0, sel_toggle}, 32'd0);
        check("rst_cnt", {30'd0, toggle_cnt}, 32'd0);
        d0 = 1'b0; d1 = 1'b1; sel = 1'b1;
        #1;
        check("rst_y_live", {31'd0, y}, 32'd1);
        sel = 1'b0;
        #1;
        check("rst_y_live0", {31'd0, y}, 32'd0);
        rst = 1'b0;

        // Randomized run against the model, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            d0  = 1'($urandom);
            d1  = 1'($urandom);
            sel = ($urandom_range(0, 3) == 0) ? ~sel : sel;
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
